// File: rtl/dut_vector_sequencer.sv
// dut_vector_sequencer
// Streams stimulus vectors into a combinational dut, holds each one for a
// programmable settle time and captures the response. The response is checked
// against a masked expectation and offered on a valid/ready result port. A
// saturating per-run error count is kept.
module dut_vector_sequencer #(
    parameter int IN_W          = 150,
    parameter int OUT_W         = 80,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_num_vectors,
    input  logic             i_vec_valid,
    output logic             o_vec_ready,
    input  logic [IN_W-1:0]  i_vec_data,
    input  logic [OUT_W-1:0] i_exp_data,
    input  logic [OUT_W-1:0] i_exp_mask,
    output logic [IN_W-1:0]  o_dut_in,
    input  logic [OUT_W-1:0] i_dut_out,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [OUT_W-1:0] o_res_data,
    output logic [CNT_W-1:0] o_res_index,
    output logic             o_res_mismatch,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_err_count
);

    // Settle counter reload value; a count of 0 means "capture this cycle".
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_EMIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start_ok;
    logic               w_accept;
    logic               w_capture;
    logic               w_handshake;
    logic               w_last;
    logic [CNT_W-1:0]   w_index_inc;
    logic               w_mismatch;

    logic [7:0]         r_settle_cnt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_index;
    logic [OUT_W-1:0]   r_exp;
    logic [OUT_W-1:0]   r_mask;
    logic [IN_W-1:0]    r_dut_in;
    logic [OUT_W-1:0]   r_res_data;
    logic [CNT_W-1:0]   r_res_index;
    logic               r_res_mismatch;
    logic [CNT_W-1:0]   r_err_count;
    logic               r_vec_ready;
    logic               r_res_valid;
    logic               r_busy;
    logic               r_done;

    // Masked compare: any differing bit that the mask selects is a mismatch.
    function automatic logic f_masked_mismatch(
        input logic [OUT_W-1:0] actual,
        input logic [OUT_W-1:0] expected,
        input logic [OUT_W-1:0] mask
    );
        return |((actual ^ expected) & mask);
    endfunction

    assign w_index_inc = r_index + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_last      = (w_index_inc == r_count);
    assign w_mismatch  = f_masked_mismatch(i_dut_out, r_exp, r_mask);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the per-cycle events that steer the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_start_ok = 1'b1;
                    if (i_num_vectors == {CNT_W{1'b0}}) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_APPLY;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_APPLY: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (i_vec_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_state_nxt = S_APPLY;
                end
            end
            S_SETTLE: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_settle_cnt == 8'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_EMIT;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_EMIT: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (i_res_ready) begin
                    w_handshake = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_APPLY;
                    end
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vec_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vec_ready <= (w_state_nxt == S_APPLY);
            r_res_valid <= (w_state_nxt == S_EMIT);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    // Run bookkeeping: latched vector count and current vector index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {CNT_W{1'b0}};
            r_index <= {CNT_W{1'b0}};
        end else if (w_start_ok) begin
            r_count <= i_num_vectors;
            r_index <= {CNT_W{1'b0}};
        end else if (w_handshake && !w_last) begin
            r_index <= w_index_inc;
        end else begin
            r_index <= r_index;
        end
    end

    // Stimulus drive, expectation latch and settle countdown.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dut_in     <= {IN_W{1'b0}};
            r_exp        <= {OUT_W{1'b0}};
            r_mask       <= {OUT_W{1'b0}};
            r_settle_cnt <= 8'd0;
        end else if (w_accept) begin
            r_dut_in     <= i_vec_data;
            r_exp        <= i_exp_data;
            r_mask       <= i_exp_mask;
            r_settle_cnt <= SETTLE_LOAD;
        end else if (r_state == S_SETTLE && r_settle_cnt != 8'd0) begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
        end else begin
            r_settle_cnt <= r_settle_cnt;
        end
    end

    // Result capture; the captured fields stay put while the result is offered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_data     <= {OUT_W{1'b0}};
            r_res_index    <= {CNT_W{1'b0}};
            r_res_mismatch <= 1'b0;
        end else if (w_capture) begin
            r_res_data     <= i_dut_out;
            r_res_index    <= r_index;
            r_res_mismatch <= w_mismatch;
        end else begin
            r_res_mismatch <= r_res_mismatch;
        end
    end

    // Saturating mismatch counter, cleared only by an accepted start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_count <= {CNT_W{1'b0}};
        end else if (w_start_ok) begin
            r_err_count <= {CNT_W{1'b0}};
        end else if (w_capture && w_mismatch && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign o_vec_ready    = r_vec_ready;
    assign o_res_valid    = r_res_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_dut_in       = r_dut_in;
    assign o_res_data     = r_res_data;
    assign o_res_index    = r_res_index;
    assign o_res_mismatch = r_res_mismatch;
    assign o_err_count    = r_err_count;

endmodule

// File: doc/dut_vector_sequencer.md
Name: dut_vector_sequencer

Overview:
Clocked controller that streams stimulus vectors into the 150-in/80-out combinational dut and captures its responses. It holds each vector on the dut input for a programmable settle time, then samples the dut output. The sample is compared against an expected vector under a per-bit mask and emitted over a valid/ready result port. It replaces file-driven single-vector benches with a multi-vector, back-pressured run and keeps an error count per run.

Parameters:
IN_W, 150, dut input width
OUT_W, 80, dut output width
CNT_W, 16, width of vector count, index and error counter
SETTLE_CYCLES, 1, cycles dut_in is held before capture; legal range 1..255

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  begin run; sampled only in IDLE
abort  input  1  synchronous cancel of current run
num_vectors  input  CNT_W  vectors in this run; latched on accepted start
vec_valid  input  1  stimulus/expected vector available
vec_ready  output  1  sequencer accepts vector
vec_data  input  IN_W  stimulus vector
exp_data  input  OUT_W  expected dut response
exp_mask  input  OUT_W  1 = compare bit, 0 = don't care
dut_in  output  IN_W  registered drive to dut input
dut_out  input  OUT_W  dut response (combinational from dut_in)
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  OUT_W  captured dut_out
res_index  output  CNT_W  0-based vector index of result
res_mismatch  output  1  masked compare failed
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at normal run completion
err_count  output  CNT_W  mismatches in current/last run

Behaviour:
- Reset values: state IDLE. dut_in, res_data, res_index, err_count = 0. vec_ready, res_valid, res_mismatch, busy, done = 0.
- IDLE, start=1 and abort=0:
  - latch num_vectors; clear err_count and index.
  - num_vectors=0 -> DONE; otherwise -> APPLY.
- APPLY: vec_ready=1.
  - On vec_valid&vec_ready: register vec_data into dut_in, latch exp_data/exp_mask, load settle counter with SETTLE_CYCLES-1, go SETTLE.
- SETTLE: counter decrements each cycle.
  - At counter=0: res_data<=dut_out; res_mismatch<=|((dut_out^exp)&mask); res_index<=index.
  - If mismatch, err_count increments, saturating at all-ones.
  - Go EMIT.
  - Latency: res_valid rises SETTLE_CYCLES cycles after the acceptance edge.
- EMIT: res_valid=1; res_data, res_index and res_mismatch stay stable until res_valid&res_ready.
  - On handshake: if index+1 == latched count -> DONE, else index++ and -> APPLY.
  - res_ready held high gives one vector per SETTLE_CYCLES+2 cycles.
- DONE: done=1 for exactly one cycle, then IDLE. err_count and dut_in hold their values until the next accepted start.
- abort=1 in any non-IDLE state:
  - next state IDLE; vec_ready/res_valid deassert next cycle; a pending result is dropped.
  - no done pulse; err_count and dut_in retain their values.
- abort and start both high in IDLE: abort wins; the run does not start.
- start while busy: ignored. num_vectors changes mid-run: ignored.
- exp_mask all zeros: never mismatches.
- rst during any state: all state and outputs return to reset values on that edge; rst takes priority over abort and start.
- Index never wraps: maximum num_vectors is 2^CNT_W-1.

Test Plan:
- Bench setup: dut is the 150/80 reference combinational dut. The expected vector comes from the golden model.
- num_vectors=3, SETTLE_CYCLES=1, res_ready=1, vectors all-zeros / all-ones / 0x...A5, correct expectations, full mask -> results with index 0,1,2 and res_mismatch=0; done one cycle after the third handshake; err_count=0.
- Same run with the expectation for vector 1 flipped at out[9] and full mask -> only index 1 has res_mismatch=1; err_count=1. Repeat with mask bit 9 = 0 -> err_count=0.
- res_ready held low for 10 cycles in EMIT -> res_valid stays 1; res_data/res_index stable; vec_ready=0; no further dut_in change.
- start with num_vectors=0 -> busy for one cycle; done pulse; err_count=0; vec_ready never asserted.
- Two scenarios combined:
  - abort asserted during SETTLE of vector 2 of 5 -> IDLE next cycle; no done; err_count unchanged; a new start runs cleanly.
  - rst mid-EMIT -> every output at its reset value on the following cycle.
